// File: rtl/wb_seq_fuzzer_if.sv
// wb_seq_fuzzer_if: Wishbone master-port bundle between the fuzzer and the slave under test
interface wb_seq_fuzzer_if;
  logic [31:0] wb_addr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic        wb_err;
  modport master (
    output wb_addr, wb_dat_o, wb_sel, wb_we, wb_stb, wb_cyc,
    input  wb_dat_i, wb_ack, wb_err
  );
  modport slave (
    input  wb_addr, wb_dat_o, wb_sel, wb_we, wb_stb, wb_cyc,
    output wb_dat_i, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_seq_fuzzer.sv
// wb_seq_fuzzer: captures Wishbone beats, mutates them with an LFSR and replays them while checking the slave
module wb_seq_fuzzer #(
  parameter int          DEPTH     = 16,
  parameter int          MUT_W     = 8,
  parameter int          MAX_WAIT  = 64,
  parameter logic [31:0] SEED      = 32'h1,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cap_stop,
  input  logic [1:0]               mode,
  input  logic [31:0]              mon_addr,
  input  logic [31:0]              mon_data,
  input  logic [3:0]               mon_sel,
  input  logic                     mon_we,
  input  logic                     mon_stb,
  input  logic                     mon_cyc,
  input  logic                     mon_ack,
  wb_seq_fuzzer_if.master          wb,
  output logic                     busy,
  output logic                     isolate,
  output logic                     done,
  output logic                     hang_detected,
  output logic                     err_detected,
  output logic                     mismatch_detected,
  output logic [$clog2(DEPTH)-1:0] fail_index,
  output logic [15:0]              tx_count
);
  localparam int          AW     = $clog2(DEPTH);
  localparam int          WW     = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] SEED_I = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LMASK  = 32'hFFFF_FFFF >> (32 - MUT_W);
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  typedef enum logic [2:0] {IDLE, CAPTURE, MUTATE, APPLY, WAIT_ACK, GAP, FINISH} state_t;
  state_t state, state_nx;
  logic [31:0] cap_addr [DEPTH];
  logic [31:0] cap_data [DEPTH];
  logic [3:0]  cap_sel  [DEPTH];
  logic        cap_we   [DEPTH];
  logic [31:0] mut_addr [DEPTH];
  logic [31:0] mut_data [DEPTH];
  logic [AW:0]   count, cnt_m1;
  logic [AW-1:0] idx;
  logic [1:0]    mode_r;
  logic [31:0]   lfsr, lfsr_nx, lm, src_addr, src_data, m_addr, m_data;
  logic [WW-1:0] wait_cnt;
  logic          fail_seen, beat, cap_full, last, timeout, bad_read, fail_ev;
  assign busy    = state != IDLE;
  assign isolate = state inside {MUTATE, APPLY, WAIT_ACK, GAP};
  assign done    = state == FINISH;
  // Shared decode: capture fill level, entry walk end, LFSR step and per-mode mutation of the current entry
  always_comb begin
    beat     = mon_cyc & mon_stb & mon_ack;
    cnt_m1   = count - (AW+1)'(1);
    last     = {1'b0, idx} == cnt_m1;
    cap_full = (count + (AW+1)'(beat)) == (AW+1)'(DEPTH);
    timeout  = wait_cnt == WW'(MAX_WAIT - 1);
    lfsr_nx  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    lm       = lfsr & LMASK;
    src_addr = cap_addr[idx];
    src_data = cap_data[idx];
    m_addr   = ((mode_r == 2'd2 ? src_addr ^ lm : src_addr) & ADDR_MASK) | ADDR_BASE;
    m_data   = mode_r == 2'd1 ? src_data ^ (lm << (32 - MUT_W)) :
               mode_r == 2'd2 ? src_data ^ lm :
               mode_r == 2'd3 ? src_data + lm : src_data;
    bad_read = !cap_we[idx] && (wb.wb_dat_i != cap_data[idx]);
    fail_ev  = state == WAIT_ACK && (wb.wb_err || (wb.wb_ack && bad_read) || timeout);
  end
  // Sequencer: err beats ack, ack beats timeout; a cap_stop with nothing captured finishes at once
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? CAPTURE : IDLE;
      CAPTURE:  state_nx = cap_full ? MUTATE : cap_stop ? ((count != '0 || beat) ? MUTATE : FINISH) : CAPTURE;
      MUTATE:   state_nx = last ? APPLY : MUTATE;
      APPLY:    state_nx = WAIT_ACK;
      WAIT_ACK: state_nx = (wb.wb_err || wb.wb_ack) ? GAP : timeout ? FINISH : WAIT_ACK;
      GAP:      state_nx = last ? FINISH : APPLY;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Control datapath, status flags and the registered master port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count             <= '0;
      idx               <= '0;
      mode_r            <= '0;
      lfsr              <= SEED_I;
      wait_cnt          <= '0;
      tx_count          <= '0;
      fail_index        <= '0;
      fail_seen         <= 1'b0;
      hang_detected     <= 1'b0;
      err_detected      <= 1'b0;
      mismatch_detected <= 1'b0;
      wb.wb_addr        <= '0;
      wb.wb_dat_o       <= '0;
      wb.wb_sel         <= '0;
      wb.wb_we          <= 1'b0;
      wb.wb_stb         <= 1'b0;
      wb.wb_cyc         <= 1'b0;
    end else begin
      if (fail_ev && !fail_seen) begin
        fail_seen  <= 1'b1;
        fail_index <= idx;
      end
      case (state)
        IDLE: if (start) begin
          count             <= '0;
          tx_count          <= '0;
          fail_index        <= '0;
          fail_seen         <= 1'b0;
          hang_detected     <= 1'b0;
          err_detected      <= 1'b0;
          mismatch_detected <= 1'b0;
          mode_r            <= mode;
        end
        CAPTURE: begin
          idx <= '0;
          if (beat) count <= count + (AW+1)'(1);
        end
        MUTATE: begin
          idx  <= last ? '0 : idx + AW'(1);
          lfsr <= lfsr_nx;
        end
        APPLY: begin
          wb.wb_addr  <= mut_addr[idx];
          wb.wb_dat_o <= mut_data[idx];
          wb.wb_sel   <= cap_sel[idx];
          wb.wb_we    <= cap_we[idx];
          wb.wb_stb   <= 1'b1;
          wb.wb_cyc   <= 1'b1;
          wait_cnt    <= '0;
        end
        WAIT_ACK: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (wb.wb_err) err_detected <= 1'b1;
          else if (wb.wb_ack) begin
            tx_count <= tx_count != 16'hFFFF ? tx_count + 16'd1 : tx_count;
            if (bad_read) mismatch_detected <= 1'b1;
          end else if (timeout) hang_detected <= 1'b1;
          if (wb.wb_err || wb.wb_ack || timeout) begin
            wb.wb_stb <= 1'b0;
            wb.wb_cyc <= 1'b0;
          end
        end
        GAP: idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end
  // Pattern buffer: captured beats are the golden copy, mutated address/data live alongside
  always_ff @(posedge clk) begin
    if (state == CAPTURE && beat) begin
      cap_addr[count[AW-1:0]] <= mon_addr;
      cap_data[count[AW-1:0]] <= mon_data;
      cap_sel[count[AW-1:0]]  <= mon_sel;
      cap_we[count[AW-1:0]]   <= mon_we;
    end
    if (state == MUTATE) begin
      mut_addr[idx] <= m_addr;
      mut_data[idx] <= m_data;
    end
  end
endmodule
